// File: rtl/reg_file.sv
// reg_file: 32 x width register file, two combinational read ports, one clocked write port, r0 hardwired to zero
module reg_file #(
  parameter int width = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4:0]                   A_addr,
  input  logic [4:0]                   B_addr,
  output logic [width-1:0]             A_data,
  output logic [width-1:0]             B_data,
  input  logic [4:0]                   W_addr,
  input  logic [width-1:0]             W_data,
  input  logic                         wr_enable,
  output logic [31:0][width-1:0]       debug_reg_out
);
  logic [31:1][width-1:0] regs_q, regs_d;
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < 32; i++)
      regs_d[i] = (wr_enable && W_addr == 5'(i)) ? W_data : regs_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end
  assign debug_reg_out = {regs_q, {width{1'b0}}};
  assign A_data = debug_reg_out[A_addr];
  assign B_data = debug_reg_out[B_addr];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file against an array model of the architectural registers
module tb_reg_file;
  logic clk = 0, reset = 0, wr_enable = 0;
  logic [4:0] A_addr = 0, B_addr = 0, W_addr = 0;
  logic [63:0] W_data = 0, A_data, B_data;
  logic [31:0][63:0] debug_reg_out;
  logic chk = 0;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0][63:0] d;
    bit cd;
  } exp_t;
  exp_t sb[$];
  logic [63:0] model [32];
  reg_file #(.width(64)) dut (
    .clk(clk), .reset(reset), .A_addr(A_addr), .B_addr(B_addr),
    .A_data(A_data), .B_data(B_data), .W_addr(W_addr), .W_data(W_data),
    .wr_enable(wr_enable), .debug_reg_out(debug_reg_out)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (chk) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (A_data !== e.a) begin
          miscompares++;
          $display("FAIL A_data addr=%0d got %h expected %h", A_addr, A_data, e.a);
        end
        vectors++;
        if (B_data !== e.b) begin
          miscompares++;
          $display("FAIL B_data addr=%0d got %h expected %h", B_addr, B_data, e.b);
        end
        if (e.cd) begin
          for (int i = 0; i < 32; i++) begin
            vectors++;
            if (debug_reg_out[i] !== e.d[i]) begin
              miscompares++;
              $display("FAIL debug_reg_out[%0d] got %h expected %h", i, debug_reg_out[i], e.d[i]);
            end
          end
        end else begin
          vectors++;
          if (debug_reg_out[0] !== 64'h0) begin
            miscompares++;
            $display("FAIL debug_reg_out[0] got %h expected 0", debug_reg_out[0]);
          end
        end
      end
    end
  end
  task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [4:0] aa, input logic [4:0] ba, input bit cd);
    exp_t e;
    reset = rst; wr_enable = we; W_addr = wa; W_data = wd; A_addr = aa; B_addr = ba; chk = 1;
    e.a = (aa == 0) ? 64'h0 : model[aa];
    e.b = (ba == 0) ? 64'h0 : model[ba];
    for (int i = 0; i < 32; i++) e.d[i] = (i == 0) ? 64'h0 : model[i];
    e.cd = cd;
    sb.push_back(e);
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) model[i] = 64'h0;
    else if (we && wa != 0) model[wa] = wd;
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    @(posedge clk); #1;
    step(1, 1, 5'd1, 64'hdeadbeef, 5'd0, 5'd0, 0);
    step(0, 1, 5'd1, 64'hdeadbeef, 5'd1, 5'd0, 1);
    step(0, 1, 5'h15, 64'hcafebabe, 5'h15, 5'd1, 1);
    step(0, 0, 5'h14, 64'hffff, 5'h15, 5'h14, 1);
    step(0, 1, 5'd0, 64'h1234, 5'd0, 5'h14, 1);
    step(0, 0, 5'd0, 64'h0, 5'd0, 5'd1, 1);
    for (int i = 1; i < 32; i++) step(0, 1, 5'(i), 64'(i + 'h100), 5'(i), 5'(31 - i), 0);
    for (int a = 0; a < 32; a++) step(0, 0, 5'(a), 64'hffff_ffff, 5'(a), 5'(31 - a), 1);
    step(1, 1, 5'd7, 64'h55, 5'd7, 5'd31, 1);
    for (int a = 0; a < 32; a += 5) step(0, 0, 5'd3, 64'h0, 5'(a), 5'(31 - a), 1);
    for (int n = 0; n < 500; n++)
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), 5'($urandom), {$urandom, $urandom},
           5'($urandom), 5'($urandom), 1);
    chk = 0;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
